// File: rtl/mj32_ctrl_pkg.sv
// Shared types and constants for the MJ32 boot/run sequencer.
package mj32_ctrl_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BOOT = 2'd2,
        RUN  = 2'd3
    } state_e;

    // Word index to byte address in instruction memory.
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] ptr);
        return ptr * XLEN'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/mj32_halt_detector.sv
// Flags a halted core: STALL_LIMIT consecutive cycles where the PC equals its previous value.
module mj32_halt_detector
    import mj32_ctrl_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    input  logic [XLEN-1:0] core_pc,
    output logic            halted_c
);

    localparam int unsigned CW = $clog2(STALL_LIMIT + 1);

    logic [XLEN-1:0] prev_pc_q, prev_pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            same_c;

    // Compare against the previous PC; first enabled cycle has nothing to compare with.
    always_comb begin
        prev_pc_d = prev_pc_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        same_c    = valid_q && (core_pc == prev_pc_q);
        halted_c  = en && same_c && (cnt_q == CW'(STALL_LIMIT - 1));
        if (clear) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (en) begin
            valid_d   = 1'b1;
            prev_pc_d = core_pc;
            if (!same_c) begin
                cnt_d = '0;
            end else if (cnt_q != CW'(STALL_LIMIT)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Stall tracking registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_pc_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            prev_pc_q <= prev_pc_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: rtl/mj32_boot_ctrl.sv
// MJ32 boot/run sequencer: load image into imem, preset PC, run core until halt or budget.
module mj32_boot_ctrl
    import mj32_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH  = 256,
    parameter int unsigned RUN_LIMIT   = 1024,
    parameter int unsigned STALL_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] start_addr,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_last,
    output logic            load_ready,
    output logic            imem_we,
    output logic [XLEN-1:0] imem_waddr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            core_reset,
    output logic            core_enable,
    output logic            core_preset,
    output logic [XLEN-1:0] core_preset_address,
    input  logic [XLEN-1:0] core_pc,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [XLEN-1:0] run_cycles
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] ptr_q, ptr_d;
    logic [XLEN-1:0] start_addr_q, start_addr_d;
    logic [XLEN-1:0] run_cycles_q, run_cycles_d;
    logic [XLEN-1:0] imem_waddr_q, imem_waddr_d;
    logic [XLEN-1:0] imem_wdata_q, imem_wdata_d;
    logic            imem_we_q, imem_we_d;
    logic            load_ready_q, load_ready_d;
    logic            core_reset_q, core_reset_d;
    logic            core_enable_q, core_enable_d;
    logic            core_preset_q, core_preset_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;

    logic            transfer_c;
    logic            last_c;
    logic            halted_c;
    logic            limit_c;
    logic [XLEN-1:0] run_next_c;

    mj32_halt_detector #(.STALL_LIMIT(STALL_LIMIT)) u_halt (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q != RUN),
        .en       (state_q == RUN),
        .core_pc  (core_pc),
        .halted_c (halted_c)
    );

    // State register plus all registered datapath/outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            start_addr_q  <= '0;
            run_cycles_q  <= '0;
            imem_waddr_q  <= '0;
            imem_wdata_q  <= '0;
            imem_we_q     <= 1'b0;
            load_ready_q  <= 1'b0;
            core_reset_q  <= 1'b1;
            core_enable_q <= 1'b0;
            core_preset_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            start_addr_q  <= start_addr_d;
            run_cycles_q  <= run_cycles_d;
            imem_waddr_q  <= imem_waddr_d;
            imem_wdata_q  <= imem_wdata_d;
            imem_we_q     <= imem_we_d;
            load_ready_q  <= load_ready_d;
            core_reset_q  <= core_reset_d;
            core_enable_q <= core_enable_d;
            core_preset_q <= core_preset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        transfer_c = (state_q == LOAD) && load_valid && load_ready_q;
        last_c     = load_last || (ptr_q == XLEN'(IMEM_DEPTH - 1));
        run_next_c = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + XLEN'(1);
        limit_c    = (state_q == RUN) && (run_next_c >= XLEN'(RUN_LIMIT));
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: if (transfer_c && last_c) state_d = BOOT;
            BOOT: state_d = RUN;
            RUN:  if (halted_c || limit_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Output/datapath next values, registered from the upcoming state.
    always_comb begin
        ptr_d        = ptr_q;
        start_addr_d = start_addr_q;
        run_cycles_d = run_cycles_q;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;
        imem_we_d    = 1'b0;
        done_d       = done_q;
        timeout_d    = timeout_q;

        if ((state_q == IDLE) && start && !abort) begin
            start_addr_d = start_addr;
            ptr_d        = '0;
            run_cycles_d = '0;
            done_d       = 1'b0;
            timeout_d    = 1'b0;
        end
        if (transfer_c && !abort) begin
            imem_we_d    = 1'b1;
            imem_waddr_d = word_addr(ptr_q);
            imem_wdata_d = load_data;
            ptr_d        = ptr_q + XLEN'(1);
        end
        if (state_q == RUN && !abort) begin
            run_cycles_d = run_next_c;
            if (halted_c)     done_d    = 1'b1;
            else if (limit_c) timeout_d = 1'b1;
        end
        if (abort) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end

        load_ready_d  = (state_d == LOAD);
        busy_d        = (state_d != IDLE);
        core_enable_d = (state_d == RUN);
        core_preset_d = (state_d == BOOT);
        // Core stays out of reset after a finished run so its state can be inspected.
        case (state_d)
            LOAD:     core_reset_d = 1'b1;
            BOOT,
            RUN:      core_reset_d = 1'b0;
            default:  core_reset_d = abort ? 1'b1 : core_reset_q;
        endcase
    end

    assign load_ready          = load_ready_q;
    assign imem_we             = imem_we_q;
    assign imem_waddr          = imem_waddr_q;
    assign imem_wdata          = imem_wdata_q;
    assign core_reset          = core_reset_q;
    assign core_enable         = core_enable_q;
    assign core_preset         = core_preset_q;
    assign core_preset_address = start_addr_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign timeout             = timeout_q;
    assign run_cycles          = run_cycles_q;

endmodule
